// File: rtl/aw_req_gen_pkg.sv
// Shared types, constants and header-decode helpers for the AW request generator.
package aw_req_gen_pkg;

  localparam int AXI_ADDR_WIDTH = 64;
  localparam int HDR_WIDTH      = 128;
  localparam int PAGE_4K_BYTES  = 4096;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {IDLE, CALC, SEND} aw_state_t;

  // A set fmt[0] (bit 29 of DW0) selects a 4DW header with a 64-bit address.
  function automatic logic [63:0] get_addr(input logic [HDR_WIDTH-1:0] hdr);
    logic [63:0] addr;
    if (hdr[29]) addr = {hdr[95:64], hdr[127:98], 2'b00};
    else         addr = {32'd0, hdr[95:66], 2'b00};
    return addr;
  endfunction

  function automatic logic [9:0] get_len_dw(input logic [HDR_WIDTH-1:0] hdr);
    return hdr[9:0];
  endfunction

  function automatic logic [7:0] get_tag_from_req_hdr(input logic [HDR_WIDTH-1:0] hdr);
    return hdr[47:40];
  endfunction

  // A length field of zero encodes 1024 DW.
  function automatic logic [12:0] get_rem_bytes(input logic [HDR_WIDTH-1:0] hdr);
    logic [9:0] len_dw;
    len_dw = get_len_dw(hdr);
    return (len_dw == 10'd0) ? 13'd4096 : {1'b0, len_dw, 2'b00};
  endfunction

  function automatic logic [8:0] calc_aw_beats(input logic [11:0] addr_lo,
                                               input logic [12:0] rem_bytes,
                                               input int          bytes,
                                               input int          max_beats);
    int off;
    int need;
    int to4k;
    int beats;
    off   = int'(addr_lo) % bytes;
    need  = (off + int'(rem_bytes) + bytes - 1) / bytes;
    to4k  = (PAGE_4K_BYTES - (int'(addr_lo) & ~(bytes - 1))) / bytes;
    beats = need;
    if (max_beats < beats) beats = max_beats;
    if (to4k < beats)      beats = to4k;
    return 9'(beats);
  endfunction

endpackage

// File: rtl/axi4_a_if.sv
// AXI4 address-channel bundle (AW or AR) with master/slave views.
interface axi4_a_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8
);
  logic                  avalid;
  logic                  aready;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic [7:0]            alen;
  logic [ID_WIDTH-1:0]   aid;
  logic [2:0]            asize;
  logic [1:0]            aburst;

  modport master (output avalid, aaddr, alen, aid, asize, aburst, input aready);
  modport slave  (input avalid, aaddr, alen, aid, asize, aburst, output aready);
endinterface

// File: rtl/aw_req_gen_hdr_fifo.sv
// Header FIFO with first-word-fall-through read so IDLE can pop and load in one cycle.
module aw_hdr_fifo #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/aw_req_gen.sv
// Queues PCIe MWr headers and splits each into 4KB-safe AXI4 INCR AW bursts.
// Optional build macro AW_HDR_BYPASS_EN lets a header skip the FIFO when idle and empty.
module aw_req_gen
  import aw_req_gen_pkg::*;
#(
  parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_BURST_BEATS = 16,
  parameter int HDR_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 aw_hdr_wren,
  input  logic [HDR_WIDTH-1:0] aw_hdr_data,
  output logic                 hdr_full,
  output logic                 aw_busy,
  output logic                 hdr_ovf,
  axi4_a_if.master             aw_if
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int ID_W  = $bits(aw_if.aid);
  localparam int CNT_W = $clog2(HDR_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BYTES - 1);

  aw_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [12:0]           rem_reg, rem_next;
  logic [7:0]            tag_reg, tag_next;
  logic [8:0]            beats_reg, beats_next;
  logic                  avalid_reg, avalid_next;
  logic [ADDR_WIDTH-1:0] aaddr_reg, aaddr_next;
  logic [7:0]            alen_reg, alen_next;
  logic [ID_W-1:0]       aid_reg, aid_next;
  logic [2:0]            asize_reg, asize_next;
  logic [1:0]            aburst_reg, aburst_next;
  logic                  hdr_ovf_reg;

  logic                  fifo_rd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [HDR_WIDTH-1:0]  fifo_rd_data;
  logic                  bypass_load;
  logic [HDR_WIDTH-1:0]  load_hdr;
  logic                  load_en;
  logic [8:0]            beats_calc;
  logic [ID_W-1:0]       tag_ext;
  logic [SIZE-1:0]       off;
  logic [31:0]           consumed;

  aw_hdr_fifo #(
    .WIDTH (HDR_WIDTH),
    .DEPTH (HDR_DEPTH)
  ) u_hdr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (aw_hdr_wren && !bypass_load),
    .wr_data (aw_hdr_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Tag is zero-extended or truncated to whatever aid width the bus carries.
  for (genvar gi = 0; gi < ID_W; gi++) begin : g_aid
    if (gi < 8) begin : g_tag_bit
      assign tag_ext[gi] = tag_reg[gi];
    end else begin : g_zero_bit
      assign tag_ext[gi] = 1'b0;
    end
  end

  assign beats_calc = calc_aw_beats(cur_addr_reg[11:0], rem_reg, BYTES, MAX_BURST_BEATS);
  assign off        = cur_addr_reg[SIZE-1:0];
  // Bytes of the request covered by the burst just accepted.
  assign consumed   = (32'(beats_reg) << SIZE) - 32'(off);
  assign load_hdr   = bypass_load ? aw_hdr_data : fifo_rd_data;

  always_comb begin
    state_next    = state_reg;
    cur_addr_next = cur_addr_reg;
    rem_next      = rem_reg;
    tag_next      = tag_reg;
    beats_next    = beats_reg;
    avalid_next   = avalid_reg;
    aaddr_next    = aaddr_reg;
    alen_next     = alen_reg;
    aid_next      = aid_reg;
    asize_next    = asize_reg;
    aburst_next   = aburst_reg;
    fifo_rd       = 1'b0;
    bypass_load   = 1'b0;
    load_en       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          load_en = 1'b1;
        end
`ifdef AW_HDR_BYPASS_EN
        else if (aw_hdr_wren) begin
          bypass_load = 1'b1;
          load_en     = 1'b1;
        end
`endif
        if (load_en) begin
          cur_addr_next = ADDR_WIDTH'(get_addr(load_hdr));
          rem_next      = get_rem_bytes(load_hdr);
          tag_next      = get_tag_from_req_hdr(load_hdr);
          state_next    = CALC;
        end
      end
      CALC: begin
        beats_next  = beats_calc;
        aaddr_next  = cur_addr_reg;
        alen_next   = 8'(beats_calc - 9'd1);
        aid_next    = tag_ext;
        asize_next  = 3'(SIZE);
        aburst_next = AXI_BURST_INCR;
        avalid_next = 1'b1;
        state_next  = SEND;
      end
      SEND: begin
        if (aw_if.aready) begin
          avalid_next   = 1'b0;
          cur_addr_next = (cur_addr_reg & ~BEAT_MASK) + (ADDR_WIDTH'(beats_reg) << SIZE);
          // The final burst can overshoot the payload when the start is unaligned.
          if (consumed >= 32'(rem_reg)) begin
            rem_next   = 13'd0;
            state_next = IDLE;
          end else begin
            rem_next   = 13'(32'(rem_reg) - consumed);
            state_next = CALC;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cur_addr_reg <= '0;
      rem_reg      <= '0;
      tag_reg      <= '0;
      beats_reg    <= '0;
      avalid_reg   <= 1'b0;
      aaddr_reg    <= '0;
      alen_reg     <= '0;
      aid_reg      <= '0;
      asize_reg    <= '0;
      aburst_reg   <= '0;
      hdr_ovf_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_addr_reg <= cur_addr_next;
      rem_reg      <= rem_next;
      tag_reg      <= tag_next;
      beats_reg    <= beats_next;
      avalid_reg   <= avalid_next;
      aaddr_reg    <= aaddr_next;
      alen_reg     <= alen_next;
      aid_reg      <= aid_next;
      asize_reg    <= asize_next;
      aburst_reg   <= aburst_next;
      if (aw_hdr_wren && fifo_full) hdr_ovf_reg <= 1'b1;
    end
  end

  assign hdr_full      = fifo_full;
  assign hdr_ovf       = hdr_ovf_reg;
  assign aw_busy       = (fifo_count != '0) || (state_reg != IDLE);
  assign aw_if.avalid  = avalid_reg;
  assign aw_if.aaddr   = aaddr_reg;
  assign aw_if.alen    = alen_reg;
  assign aw_if.aid     = aid_reg;
  assign aw_if.asize   = asize_reg;
  assign aw_if.aburst  = aburst_reg;

endmodule

// File: tb/tb_aw_req_gen.sv
// Directed bench for aw_req_gen: burst splitting, latency, FIFO full/overflow and reset.
module tb_aw_req_gen;

  localparam int AW = 64;
  localparam int IW = 8;
`ifdef AW_HDR_BYPASS_EN
  localparam int LAT_FIRST = 2;
`else
  localparam int LAT_FIRST = 3;
`endif

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          cyc;
  } aw_rec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         aw_hdr_wren;
  logic [127:0] aw_hdr_data;
  logic         hdr_full;
  logic         aw_busy;
  logic         hdr_ovf;
  int           cyc = 0;
  int           n_total = 0;
  int           n_pass = 0;
  int           n_fail = 0;
  int           push_cyc;
  aw_rec_t      hs_q[$];

  axi4_a_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) aw_bus ();

  aw_req_gen #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (256),
    .MAX_BURST_BEATS (16),
    .HDR_DEPTH       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .aw_hdr_wren (aw_hdr_wren),
    .aw_hdr_data (aw_hdr_data),
    .hdr_full    (hdr_full),
    .aw_busy     (aw_busy),
    .hdr_ovf     (hdr_ovf),
    .aw_if       (aw_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && aw_bus.avalid && aw_bus.aready) begin
      hs_q.push_back('{addr: aw_bus.aaddr, len: aw_bus.alen, id: aw_bus.aid,
                       size: aw_bus.asize, burst: aw_bus.aburst, cyc: cyc});
      $display("AW cyc=%0d addr=0x%0h alen=%0d aid=0x%0h asize=%0d aburst=%0d",
               cyc, aw_bus.aaddr, aw_bus.alen, aw_bus.aid, aw_bus.asize, aw_bus.aburst);
    end
  end

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_hdr(input logic [31:0] addr, input logic [9:0] len,
                                          input logic [7:0] tag);
    logic [127:0] h;
    h          = '0;
    h[31:24]   = 8'h40;
    h[9:0]     = len;
    h[47:40]   = tag;
    h[95:64]   = addr;
    return h;
  endfunction

  task automatic push(input logic [31:0] addr, input logic [9:0] len, input logic [7:0] tag);
    aw_hdr_data = mk_hdr(addr, len, tag);
    aw_hdr_wren = 1'b1;
    push_cyc    = cyc;
    @(posedge clk); #1;
    aw_hdr_wren = 1'b0;
  endtask

  task automatic wait_idle(input string t, input int budget);
    int n = 0;
    while (aw_busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({t, "_busy_drop"}, 64'(aw_busy), 64'(0));
  endtask

  task automatic wait_avalid(input string t, input int budget);
    int n = 0;
    while (!aw_bus.avalid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({t, "_avalid_up"}, 64'(aw_bus.avalid), 64'(1));
  endtask

  task automatic chk_aw(input string t, input int idx, input logic [63:0] a,
                        input logic [7:0] l, input logic [7:0] id);
    if (idx < hs_q.size()) begin
      chk({t, "_aaddr"}, hs_q[idx].addr, a);
      chk({t, "_alen"}, 64'(hs_q[idx].len), 64'(l));
      chk({t, "_aid"}, 64'(hs_q[idx].id), 64'(id));
    end else begin
      chk({t, "_present"}, 64'(hs_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    aw_hdr_wren    = 1'b0;
    aw_hdr_data    = '0;
    aw_bus.aready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avalid", 64'(aw_bus.avalid), 64'(0));
    chk("rst_aaddr", aw_bus.aaddr, 64'(0));
    chk("rst_alen", 64'(aw_bus.alen), 64'(0));
    chk("rst_aid", 64'(aw_bus.aid), 64'(0));
    chk("rst_asize", 64'(aw_bus.asize), 64'(0));
    chk("rst_aburst", 64'(aw_bus.aburst), 64'(0));
    chk("rst_hdr_ovf", 64'(hdr_ovf), 64'(0));
    chk("rst_hdr_full", 64'(hdr_full), 64'(0));
    chk("rst_aw_busy", 64'(aw_busy), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single aligned burst
    hs_q.delete();
    push(32'h1000, 10'd8, 8'h05);
    wait_idle("t1", 40);
    chk("t1_count", 64'(hs_q.size()), 64'(1));
    chk_aw("t1", 0, 64'h1000, 8'd0, 8'h05);
    if (hs_q.size() > 0) begin
      chk("t1_asize", 64'(hs_q[0].size), 64'(5));
      chk("t1_aburst", 64'(hs_q[0].burst), 64'(1));
      chk("t1_latency", 64'(hs_q[0].cyc - push_cyc), 64'(LAT_FIRST));
    end

    // 1 KB split by MAX_BURST_BEATS
    hs_q.delete();
    push(32'h0000, 10'd256, 8'h06);
    wait_idle("t2", 60);
    chk("t2_count", 64'(hs_q.size()), 64'(2));
    chk_aw("t2_b0", 0, 64'h0000, 8'd15, 8'h06);
    chk_aw("t2_b1", 1, 64'h0200, 8'd15, 8'h06);
    if (hs_q.size() > 1) chk("t2_gap", 64'(hs_q[1].cyc - hs_q[0].cyc), 64'(2));

    // 4 KB boundary split
    hs_q.delete();
    push(32'h0FE0, 10'd16, 8'h07);
    wait_idle("t3", 60);
    chk("t3_count", 64'(hs_q.size()), 64'(2));
    chk_aw("t3_b0", 0, 64'h0FE0, 8'd0, 8'h07);
    chk_aw("t3_b1", 1, 64'h1000, 8'd0, 8'h07);

    // unaligned start, then a queued 1024 DW request
    hs_q.delete();
    push(32'h1004, 10'd8, 8'h08);
    push(32'h0000, 10'd0, 8'h09);
    wait_idle("t4", 200);
    chk("t4_count", 64'(hs_q.size()), 64'(9));
    chk_aw("t4_unal", 0, 64'h1004, 8'd1, 8'h08);
    for (int k = 0; k < 8; k++) begin
      chk_aw($sformatf("t5_b%0d", k), k + 1, 64'(k * 32'h200), 8'd15, 8'h09);
    end
    if (hs_q.size() > 1) chk("t5_next_req_gap", 64'(hs_q[1].cyc - hs_q[0].cyc), 64'(3));

    // back-pressure: FIFO fills, fifth stalled push overflows
    hs_q.delete();
    aw_bus.aready = 1'b0;
    push(32'h2000, 10'd8, 8'h10);
    wait_avalid("t6", 10);
    for (int k = 1; k <= 5; k++) begin
      push(32'h3000 + 32'(k) * 32'h100, 10'd8, 8'(8'h10 + k));
      if (k == 3) chk("t6_not_full_3", 64'(hdr_full), 64'(0));
      if (k == 4) begin
        chk("t6_full_4", 64'(hdr_full), 64'(1));
        chk("t6_no_ovf_4", 64'(hdr_ovf), 64'(0));
      end
      if (k == 5) chk("t6_ovf_5", 64'(hdr_ovf), 64'(1));
    end
    repeat (4) @(posedge clk);
    #1;
    chk("t6_hold_avalid", 64'(aw_bus.avalid), 64'(1));
    chk("t6_hold_aaddr", aw_bus.aaddr, 64'h2000);
    chk("t6_hold_aid", 64'(aw_bus.aid), 64'h10);
    chk("t6_hold_alen", 64'(aw_bus.alen), 64'(0));
    chk("t6_no_hs", 64'(hs_q.size()), 64'(0));
    aw_bus.aready = 1'b1;
    wait_idle("t6", 100);
    chk("t6_count", 64'(hs_q.size()), 64'(5));
    chk_aw("t6_a", 0, 64'h2000, 8'd0, 8'h10);
    for (int k = 1; k <= 4; k++) begin
      chk_aw($sformatf("t6_q%0d", k), k, 64'h3000 + 64'(k) * 64'h100, 8'd0, 8'(8'h10 + k));
    end
    chk("t6_ovf_sticky", 64'(hdr_ovf), 64'(1));

    // reset while a burst is waiting for aready
    hs_q.delete();
    aw_bus.aready = 1'b0;
    push(32'h4000, 10'd256, 8'h30);
    push(32'h5000, 10'd8, 8'h31);
    wait_avalid("t7", 10);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_avalid", 64'(aw_bus.avalid), 64'(0));
    chk("t7_rst_busy", 64'(aw_busy), 64'(0));
    chk("t7_rst_ovf", 64'(hdr_ovf), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    aw_bus.aready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t7_no_aw", 64'(hs_q.size()), 64'(0));
    chk("t7_idle_busy", 64'(aw_busy), 64'(0));
    push(32'h6000, 10'd8, 8'h32);
    wait_idle("t7_new", 40);
    chk("t7_new_count", 64'(hs_q.size()), 64'(1));
    chk_aw("t7_new", 0, 64'h6000, 8'd0, 8'h32);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
